serial_chunk_adder: RTL and testbench



---
 rtl/serial_chunk_adder_pkg.sv | 16 +
 rtl/serial_chunk_adder_chunk_ripple.sv | 21 ++
 rtl/serial_chunk_adder.sv | 108 ++++++++++
 tb/tb_serial_chunk_adder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// serial_chunk_adder_pkg: shared FSM encodings, full-adder cell and config check
package serial_chunk_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    function automatic bit chunk_cfg_ok(input int w, input int c);
        return (w >= 2) && (c >= 1) && (c <= w) && (w % c == 0);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_ripple.sv
// chunk_ripple: combinational CHUNK-bit ripple chain of full adders
module chunk_ripple
    import serial_chunk_adder_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             c_in,
    output logic [CHUNK-1:0] s_c,
    output logic             c_out
);
    logic [CHUNK:0] c;

    assign c[0]  = c_in;
    assign c_out = c[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign {c[i+1], s_c[i]} = full_add(a_c[i], b_c[i], c[i]);
    end
endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add the sub_i port (a - b mode).
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   sum_o
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh, mask;
    logic [CHUNK-1:0] s_c;
    logic             c_out;
    logic             sub_en;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    assign sub_en = sub_i;
`else
    assign sub_en = 1'b0;
`endif

    // shifting instead of indexed part-selects keeps the select widths exact
    assign base = 32'(cnt_q) * 32'(CHUNK);
    assign a_sh = a_q >> base;
    assign b_sh = b_q >> base;
    assign mask = WIDTH'({CHUNK{1'b1}}) << base;

    chunk_ripple #(.CHUNK(CHUNK)) u_rip (
        .a_c   (a_sh[CHUNK-1:0]),
        .b_c   (b_sh[CHUNK-1:0]),
        .c_in  (carry_q),
        .s_c   (s_c),
        .c_out (c_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        if (state_q == IDLE && start_i) begin
            a_d     = a_i;
            b_d     = sub_en ? ~b_i : b_i;
            carry_d = sub_en | cin_i;
            sum_d   = '0;
            cnt_d   = '0;
            state_d = ADD;
        end else if (state_q == ADD) begin
            sum_d[WIDTH-1:0] = (sum_q[WIDTH-1:0] & ~mask) | ((WIDTH'(s_c) << base) & mask);
            carry_d          = c_out;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CW'(NCHUNK - 1)) begin
                sum_d[WIDTH] = c_out;
                state_d      = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

    assign busy_o = (state_q == ADD);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed checks of serial_chunk_adder across CHUNK/WIDTH configs
module tb_serial_chunk_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8 [4];
    logic        done8 [4];
    logic [8:0]  sum8  [4];
    logic        busy16, done16;
    logic [16:0] sum16;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_chunk_adder #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start_i (start),
            .a_i     (a),
            .b_i     (b),
            .cin_i   (cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
            .sub_i   (sub),
`endif
            .busy_o  (busy8[g]),
            .done_o  (done8[g]),
            .sum_o   (sum8[g])
        );
    end

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a16),
        .b_i     (b16),
        .cin_i   (cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy16),
        .done_o  (done16),
        .sum_o   (sum16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        return s ? {1'b0, x} + {1'b0, ~y} + 9'd1 : {1'b0, x} + {1'b0, y} + {8'd0, c};
    endfunction

    function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        return s ? {1'b0, x} + {1'b0, ~y} + 17'd1 : {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    // latency counted from the cycle start is driven: done expected in cycle NCHUNK+1
    task automatic run(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] ta16,
                       input logic [15:0] tb16, input logic tc, input logic ts, input logic [8:0] exp_main);
        int lat [5];
        int dn  [5];
        int nb;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            lat[i] = -1;
            dn[i]  = 0;
        end
        @(negedge clk);
        a = ta; b = tb; a16 = ta16; b16 = tb16; cin = tc; sub = ts; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy8[1]) nb++;
            for (int i = 0; i < 4; i++) if (done8[i]) begin
                dn[i]++;
                if (lat[i] < 0) lat[i] = c;
            end
            if (done16) begin
                dn[4]++;
                if (lat[4] < 0) lat[4] = c;
            end
        end
        chk("busy_cycles", nb, 4);
        chk("sum_main", sum8[1], exp_main);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("latency_c%0d", 1 << i), lat[i], (8 >> i) + 1);
            chk($sformatf("done_pulses_c%0d", 1 << i), dn[i], 1);
            chk($sformatf("sum_c%0d", 1 << i), sum8[i], model8(ta, tb, tc, ts));
        end
        chk("latency_w16", lat[4], 5);
        chk("done_pulses_w16", dn[4], 1);
        chk("sum_w16", sum16, model16(ta16, tb16, tc, ts));
    endtask

    initial begin
        int dn;
        logic [7:0] ra, rb;
        logic rc;
        #1;
        chk("reset_busy", busy8[1], 0);
        chk("reset_done", done8[1], 0);
        chk("reset_sum", sum8[1], 0);
        @(negedge clk);
        rst = 1'b0;

        run(8'hAD, 8'h39, 16'h1234, 16'hF0F0, 1'b0, 1'b0, 9'h0E6);
        run(8'hFF, 8'h01, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 9'h100);
        run(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 9'h1FF);
        run(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 9'h000);
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        run(8'h39, 8'hAD, 16'h0039, 16'h00AD, 1'b0, 1'b1, 9'h08C);
        run(8'hAD, 8'h39, 16'h00AD, 16'h0039, 1'b1, 1'b1, 9'h174);
`endif

        // second start two cycles into ADD must be ignored
        dn = 0;
        @(negedge clk);
        a = 8'hAD; b = 8'h39; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (c == 2) begin
                a = 8'h01;
                b = 8'h01;
            end
            if (done8[1]) dn++;
        end
        chk("busy_start_pulses", dn, 1);
        chk("busy_start_sum", sum8[1], 9'h0E6);

        // asynchronous reset two cycles after start aborts the operation
        dn = 0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy8[1], 0);
        chk("midrst_done", done8[1], 0);
        chk("midrst_sum", sum8[1], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done8[1]) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run(8'h5A, 8'hA5, 16'hABCD, 16'h1357, 1'b1, 1'b0, 9'h100);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run(ra, rb, 16'($urandom), 16'($urandom), rc, 1'b0, model8(ra, rb, rc, 1'b0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
